// File: rtl/alu16_serial_seq.sv
// ---------------------------------------------------------------------------
// alu16_serial_seq
//
// Bit-serial 16-bit ALU sequencer. Operands are shifted LSB first through an
// external combinational 1-bit ALU slice, one bit per clock. The result is
// assembled in a right-shifting register. Carry, zero and overflow flags are
// produced at the end of the operation.
//
// State table
//   state | meaning
//   IDLE  | ready for a new request; slice drives held at 0
//   RUN   | 16 cycles, one slice evaluation per cycle, LSB first
//   FIN   | one-cycle completion (DONE=1); result and flags visible
//
// Ports
//   CLK        in   clock, rising edge active
//   RST        in   synchronous active-high reset
//   START      in   operation request, taken only in IDLE
//   A, B       in   16-bit operands, captured on accept
//   OP         in   {P, C1, C2, C3}; P inverts B inside the slice
//   ABORT      in   cancels an operation while in RUN
//   READY      out  high in IDLE
//   DONE       out  high for the single FIN cycle
//   RESULT     out  result register, written only on completion
//   CF/ZF/VF   out  carry / zero / overflow, written with RESULT
//   SA..SC3    out  drives to the external slice (0 outside RUN)
//   SO, SCOUT  in   slice sum/logic output and carry out, same cycle
// ---------------------------------------------------------------------------
module alu16_serial_seq (
    input  logic        CLK,
    input  logic        RST,
    input  logic        START,
    input  logic [15:0] A,
    input  logic [15:0] B,
    input  logic [3:0]  OP,
    input  logic        ABORT,
    output logic        READY,
    output logic        DONE,
    output logic [15:0] RESULT,
    output logic        CF,
    output logic        ZF,
    output logic        VF,
    output logic        SA,
    output logic        SB,
    output logic        SP,
    output logic        SCIN,
    output logic        SC1,
    output logic        SC2,
    output logic        SC3,
    input  logic        SO,
    input  logic        SCOUT
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [15:0] a_sr;
    logic [15:0] b_sr;
    logic [15:0] res_sr;
    logic [3:0]  op_q;
    logic [3:0]  cnt;
    logic        carry;

    logic        accept;
    logic        last_bit;
    logic        op_arith;
    logic        in_arith;
    logic [15:0] res_nxt;

    // Codes 110 and 111 are ADD (or SUB when P is set).
    assign op_arith = op_q[2] & op_q[1];
    assign in_arith = OP[2] & OP[1];
    assign accept   = (state == IDLE) && START;
    assign last_bit = (cnt == 4'd15);
    assign res_nxt  = {SO, res_sr[15:1]};

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // Next state and outputs
    // -----------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        READY     = 1'b0;
        DONE      = 1'b0;
        SA        = 1'b0;
        SB        = 1'b0;
        SP        = 1'b0;
        SCIN      = 1'b0;
        SC1       = 1'b0;
        SC2       = 1'b0;
        SC3       = 1'b0;

        case (state)
            IDLE: begin
                READY = 1'b1;
                // START wins over a simultaneous ABORT here.
                if (START) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                SA   = a_sr[0];
                SB   = b_sr[0];
                SP   = op_q[3];
                SC1  = op_q[2];
                SC2  = op_q[1];
                SC3  = op_q[0];
                SCIN = carry;
                if (ABORT) begin
                    state_nxt = IDLE;
                end else if (last_bit) begin
                    state_nxt = FIN;
                end
            end
            FIN: begin
                // ABORT is not looked at: completion always reports.
                DONE      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Operand / result shift registers, counter and carry
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            a_sr   <= 16'h0000;
            b_sr   <= 16'h0000;
            res_sr <= 16'h0000;
            op_q   <= 4'h0;
            cnt    <= 4'd0;
            carry  <= 1'b0;
        end else if (accept) begin
            a_sr   <= A;
            b_sr   <= B;
            res_sr <= 16'h0000;
            op_q   <= OP;
            cnt    <= 4'd0;
            // SUB is A + ~B + 1: the slice inverts B, the +1 enters here.
            carry  <= in_arith & OP[3];
        end else if ((state == RUN) && !ABORT) begin
            a_sr   <= {1'b0, a_sr[15:1]};
            b_sr   <= {1'b0, b_sr[15:1]};
            res_sr <= res_nxt;
            cnt    <= cnt + 4'd1;
            carry  <= op_arith & SCOUT;
        end
    end

    // -----------------------------------------------------------------------
    // Result and flags: written only on the last RUN edge, so accept, abort
    // and idle cycles leave them untouched.
    // Overflow uses the carry into the MSB (the carry register while bit 15
    // is on the slice) against the carry out of the MSB.
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            RESULT <= 16'h0000;
            CF     <= 1'b0;
            ZF     <= 1'b0;
            VF     <= 1'b0;
        end else if ((state == RUN) && !ABORT && last_bit) begin
            RESULT <= res_nxt;
            CF     <= op_arith & SCOUT;
            ZF     <= (res_nxt == 16'h0000);
            VF     <= op_arith & (carry ^ SCOUT);
        end
    end

endmodule

// File: tb/tb_alu16_serial_seq.sv
module tb_alu16_serial_seq;

    logic        CLK = 1'b0;
    logic        RST;
    logic        START;
    logic [15:0] A;
    logic [15:0] B;
    logic [3:0]  OP;
    logic        ABORT;
    logic        READY;
    logic        DONE;
    logic [15:0] RESULT;
    logic        CF, ZF, VF;
    logic        SA, SB, SP, SCIN, SC1, SC2, SC3;
    logic        SO, SCOUT;

    int checks = 0;
    int errors = 0;

    alu16_serial_seq dut (
        .CLK    (CLK),
        .RST    (RST),
        .START  (START),
        .A      (A),
        .B      (B),
        .OP     (OP),
        .ABORT  (ABORT),
        .READY  (READY),
        .DONE   (DONE),
        .RESULT (RESULT),
        .CF     (CF),
        .ZF     (ZF),
        .VF     (VF),
        .SA     (SA),
        .SB     (SB),
        .SP     (SP),
        .SCIN   (SCIN),
        .SC1    (SC1),
        .SC2    (SC2),
        .SC3    (SC3),
        .SO     (SO),
        .SCOUT  (SCOUT)
    );

    always #5 CLK = ~CLK;

    // External 1-bit slice model.
    logic bx;
    always_comb begin
        bx    = SB ^ SP;
        SO    = 1'b0;
        SCOUT = 1'b0;
        case ({SC1, SC2, SC3})
            3'b000: SO = ~(SA | bx);
            3'b001: SO = ~(SA & bx);
            3'b010: SO = SA | bx;
            3'b011: SO = SA & bx;
            3'b100: SO = SA ^ bx;
            3'b101: SO = ~(SA ^ bx);
            default: begin
                SO    = SA ^ bx ^ SCIN;
                SCOUT = (SA & bx) | (SA & SCIN) | (bx & SCIN);
            end
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [6:0] slice_bus();
        return {SA, SB, SP, SCIN, SC1, SC2, SC3};
    endfunction

    // Full operation from IDLE; checks first slice drive, latency, result,
    // flags and FIN/IDLE behaviour.
    task automatic do_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic [3:0] op, input logic [15:0] er,
                         input logic ecf, input logic ezf, input logic evf,
                         input logic abort_acc, input logic abort_fin);
        int n;
        START = 1'b1;
        ABORT = abort_acc;
        A = a; B = b; OP = op;
        tick();
        START = 1'b0;
        ABORT = 1'b0;
        check({tag, "_run_ready"}, 32'(READY), 32'd0);
        check({tag, "_drv0"}, 32'(slice_bus()),
              32'({a[0], b[0], op[3], op[3] & op[2] & op[1], op[2], op[1], op[0]}));
        n = 0;
        while (!DONE && n < 40) begin
            tick();
            n++;
        end
        check({tag, "_lat"}, 32'(n), 32'd16);
        check({tag, "_res"}, 32'(RESULT), 32'(er));
        check({tag, "_flags"}, 32'({CF, ZF, VF}), 32'({ecf, ezf, evf}));
        check({tag, "_fin"}, 32'({READY, slice_bus()}), 32'd0);
        ABORT = abort_fin;
        tick();
        ABORT = 1'b0;
        check({tag, "_idle"}, 32'({READY, DONE}), 32'b10);
        check({tag, "_hold"}, 32'({RESULT, CF, ZF, VF}), 32'({er, ecf, ezf, evf}));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int dones;
        RST = 1'b1; START = 1'b0; ABORT = 1'b0;
        A = 16'h0; B = 16'h0; OP = 4'h0;
        tick(); tick();
        RST = 1'b0;
        check("rst_ctl", 32'({READY, DONE}), 32'b10);
        check("rst_res", 32'({RESULT, CF, ZF, VF}), 32'd0);
        check("rst_drv", 32'(slice_bus()), 32'd0);

        // V1 ADD overflow
        do_op("v1_add", 16'h7FFF, 16'h0001, 4'b0110, 16'h8000, 0, 0, 1, 0, 0);
        // V2 SUB (START+ABORT together at accept; ABORT in FIN ignored)
        do_op("v2_sub0", 16'h0005, 16'h0005, 4'b1110, 16'h0000, 1, 1, 0, 1, 1);
        do_op("v2_subn", 16'h0003, 16'h0005, 4'b1110, 16'hFFFE, 0, 0, 0, 0, 0);
        // V3 logic
        do_op("v3_and",  16'hF0F0, 16'h3C3C, 4'b0011, 16'h3030, 0, 0, 0, 0, 0);
        do_op("v3_or",   16'hF0F0, 16'h3C3C, 4'b0010, 16'hFCFC, 0, 0, 0, 0, 0);
        do_op("v3_xor",  16'hF0F0, 16'h3C3C, 4'b0100, 16'hCCCC, 0, 0, 0, 0, 0);
        do_op("v3_xnor", 16'hF0F0, 16'h3C3C, 4'b0101, 16'h3333, 0, 0, 0, 0, 0);
        do_op("v3_nand", 16'hF0F0, 16'h3C3C, 4'b0001, 16'hCFCF, 0, 0, 0, 0, 0);
        do_op("v3_nor",  16'h0000, 16'h0000, 4'b0000, 16'hFFFF, 0, 0, 0, 0, 0);
        do_op("v3_sub7", 16'h8000, 16'h0001, 4'b1111, 16'h7FFF, 1, 0, 1, 0, 0);

        // V4a: START pulsed in RUN cycle 5 is ignored and not queued
        START = 1'b1; A = 16'h1234; B = 16'h1111; OP = 4'b0110;
        tick();
        START = 1'b0;
        n = 1;
        repeat (4) tick();
        START = 1'b1; A = 16'hFFFF; B = 16'hFFFF;
        tick();
        START = 1'b0;
        n = 5;
        while (!DONE && n < 40) begin
            tick();
            n++;
        end
        check("v4_lat", 32'(n), 32'd16);
        check("v4_res", 32'(RESULT), 32'h2345);
        dones = 0;
        repeat (20) begin
            tick();
            if (DONE) dones++;
        end
        check("v4_noqueue", 32'(dones), 32'd0);

        // V4b: ABORT while bit 7 is on the slice
        START = 1'b1; A = 16'h0F0F; B = 16'h0101; OP = 4'b0110;
        tick();
        START = 1'b0;
        repeat (7) tick();
        check("v4_bit7_sa", 32'({SA, SB}), 32'b00);
        ABORT = 1'b1;
        tick();
        ABORT = 1'b0;
        check("v4_abort_ctl", 32'({READY, DONE}), 32'b10);
        check("v4_abort_res", 32'({RESULT, CF, ZF, VF}), 32'({16'h2345, 3'b000}));
        dones = 0;
        repeat (20) begin
            tick();
            if (DONE) dones++;
        end
        check("v4_abort_nodone", 32'(dones), 32'd0);

        // V5: reset at bit 10 of an ADD
        START = 1'b1; A = 16'hFFFF; B = 16'h0001; OP = 4'b0110;
        tick();
        START = 1'b0;
        repeat (10) tick();
        RST = 1'b1; START = 1'b1; ABORT = 1'b1;
        tick();
        RST = 1'b0; START = 1'b0; ABORT = 1'b0;
        check("v5_ctl", 32'({READY, DONE}), 32'b10);
        check("v5_res", 32'({RESULT, CF, ZF, VF}), 32'd0);
        check("v5_drv", 32'(slice_bus()), 32'd0);
        do_op("v5_add", 16'h0001, 16'h0001, 4'b0110, 16'h0002, 0, 0, 0, 0, 0);

        // V6: START held high -> one op every 18 cycles
        START = 1'b1; A = 16'h0001; B = 16'h0002; OP = 4'b0110;
        tick();
        dones = 0;
        for (int c = 1; c <= 56; c++) begin
            tick();
            if (DONE) begin
                check("v6_done_pos", 32'(c), 32'(16 + 18 * dones));
                check("v6_fin_ready", 32'(READY), 32'd0);
                check("v6_res", 32'(RESULT), 32'h0003);
                dones++;
            end
        end
        check("v6_count", 32'(dones), 32'd3);
        START = 1'b0;
        n = 0;
        while (!READY && n < 40) begin
            tick();
            n++;
        end
        check("v6_back_idle", 32'(READY), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu16_serial_seq.md
ALU16_SERIAL_SEQ -- requirements
Module: alu16_serial_seq

Interface
REQ-001 CLK  input  1  single clock; all state changes on the rising edge.
REQ-002 RST  input  1  reset; synchronous, active-high.
REQ-003 START  input  1  operation request; accepted only when READY=1.
REQ-004 A  input  16  operand A; captured on accept.
REQ-005 B  input  16  operand B; captured on accept.
REQ-006 OP  input  4  operation code; captured on accept. OP[3] = P (B invert). OP[2:0] = {C1,C2,C3}.
REQ-007 ABORT  input  1  cancels an operation in progress.
REQ-008 READY  output  1  high in IDLE only.
REQ-009 DONE  output  1  one-cycle completion pulse.
REQ-010 RESULT  output  16  result register; updated only on completion.
REQ-011 CF / ZF / VF  output  1 each  carry, zero and overflow flags; updated with RESULT.
REQ-012 SA, SB, SP, SCIN, SC1, SC2, SC3  output  1 each  drive to the external 1-bit ALU slice.
REQ-013 SO, SCOUT  input  1 each  combinational slice result and carry, valid in the same cycle.

Function
REQ-014 OP[2:0] decoding for slice select {C1,C2,C3}:
- 000 NOR, 001 NAND, 010 OR, 011 AND, 100 XOR, 101 XNOR.
- 110 and 111 ADD.
- OP[2:0] is arithmetic when OP[2] and OP[1] are both 1 (codes 110, 111).
- With OP[3]=1 on an arithmetic code, the operation is SUB (A - B).
REQ-015 The block SHALL have three states: IDLE, RUN and FIN.
REQ-016 Accept: IDLE with START=1.
- Load operand shift registers from A and B, and latch OP.
- Bit counter <= 0.
- Carry register <= OP[3] if arithmetic, else 0.
- Next state RUN.
REQ-017 In RUN, each cycle the block SHALL drive the slice for bit k, LSB first:
- SA = A[k], SB = B[k].
- SP = OP[3], {SC1,SC2,SC3} = OP[2:0].
- SCIN = carry register.
REQ-018 Each RUN edge SHALL:
- shift SO into the result shift register MSB, shifting right;
- load carry <= SCOUT if arithmetic, else 0;
- increment the counter.
REQ-019 When k=15 the block SHALL save SCIN as the MSB carry-in and move to FIN.
- RUN lasts exactly 16 cycles.
REQ-020 FIN SHALL last one cycle and then return to IDLE. In the FIN cycle:
- DONE=1 and READY=0.
- RESULT, CF, ZF and VF show the new values.
REQ-021 Latency: with accept at edge E0, bits are sampled at E1..E16 and DONE is high in the cycle after E16.
REQ-022 Flag rules:
- CF = final carry if arithmetic, else 0.
- ZF = (RESULT == 0).
- VF = MSB carry-in XOR final carry if arithmetic, else 0.
- For SUB, CF=1 means no borrow.
REQ-023 RESULT and the flags SHALL hold until the next completion.
- They are unchanged by accept, abort or idle cycles.
REQ-024 START while READY=0 SHALL be ignored and not queued.
REQ-025 START and ABORT together in IDLE: START is accepted and ABORT is ignored.
REQ-026 ABORT in RUN SHALL return the block to IDLE at the next edge.
- No DONE pulse is produced.
- RESULT and flags are unchanged.
- ABORT in FIN is ignored and DONE still pulses.
REQ-027 In IDLE and FIN, all slice drive outputs SHALL be 0.

Reset
REQ-028 RST=1 at an edge SHALL force IDLE, from any state including mid-RUN.
- DONE=0, READY=1 in the following cycle.
- RESULT=0x0000, CF=0, ZF=0, VF=0.
- Slice drives all 0; counter, carry and shift registers cleared.
REQ-029 RST SHALL take priority over START and ABORT.

Verification
REQ-030 The bench SHALL model the slice per REQ-014 and cover the following scenarios:
- V1: ADD, OP=0110, A=0x7FFF, B=0x0001 -> RESULT=0x8000, CF=0, ZF=0, VF=1; DONE exactly 16 cycles after the accept edge.
- V2: SUB, OP=1110, A=0x0005, B=0x0005 -> RESULT=0x0000, CF=1, ZF=1, VF=0. Then A=0x0003, B=0x0005 -> 0xFFFE, CF=0.
- V3: logic ops with A=0xF0F0, B=0x3C3C, flags CF=VF=0 throughout:
  - AND (0011) -> 0x3030.
  - OR (0010) -> 0xFCFC.
  - XOR (0100) -> 0xCCCC.
  - XNOR (0101) -> 0x3333.
  - NAND (0001) -> 0xCFCF.
  - NOR (0000) with A=B=0x0000 -> 0xFFFF.
- V4: START pulsed at RUN cycle 5 is ignored. ABORT at bit 7 of the next op -> READY=1 next cycle, no DONE, RESULT keeps the prior value.
- V5: RST at bit 10 of an ADD -> all outputs at reset values next cycle. A new ADD 0x0001+0x0001 then completes with 0x0002.
- V6: START held high continuously -> one operation per 18 cycles; START ignored during the FIN cycle.
